// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encodings, statistics
// counter width and a constant log2 helper used for index widths.
package fifo_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  localparam int STAT_W = 16;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_OWN  = ST_OWN
  } arb_state_e;

  // Width needed to index 'value' items; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first set request at or after rr_ptr,
// wrapping from N_REQ-1 back to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [clog2(N_REQ)-1:0] rr_ptr,
  output logic [clog2(N_REQ)-1:0] winner,
  output logic                    valid
);

  localparam int IDX_W = clog2(N_REQ);

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-requester saturating grant counters (stat_cnt).
//
// state | meaning
// IDLE  | arbitrate from rr_ptr; a grant here starts a burst (or rotates if MAX_BURST==1)
// OWN   | locked to owner until MAX_BURST grants, owner drops req, or reset
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              grant,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  output logic [clog2(N_REQ)-1:0]       owner,
`ifdef FIFO_ARB_STATS_EN
  output logic [N_REQ*STAT_W-1:0]       stat_cnt,
`endif
  output logic                          busy
);

  localparam int         IDX_W      = clog2(N_REQ);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [7:0]       burst_q, burst_d;
  logic [N_REQ-1:0] grant_c;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    grant_c  = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid && !fifo_full) begin
          grant_c[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          if (MAX_BURST == 1) begin
            rr_ptr_d = next_idx(pick_idx);
          end else begin
            state_d = S_OWN;
            burst_d = 8'd1;
          end
        end
      end
      S_OWN: begin
        if (req[owner_q]) begin
          // A full FIFO only stalls the burst; the lock and count are kept.
          if (!fifo_full) begin
            grant_c[owner_q] = 1'b1;
            if (burst_q == BURST_LAST) begin
              state_d  = S_IDLE;
              rr_ptr_d = next_idx(owner_q);
              burst_d  = 8'd0;
            end else begin
              burst_d = burst_q + 8'd1;
            end
          end
        end else begin
          state_d  = S_IDLE;
          rr_ptr_d = next_idx(owner_q);
          burst_d  = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) grant_c = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      burst_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      burst_q  <= burst_d;
    end
  end

  always_comb begin
    fifo_w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) fifo_w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant   = grant_c;
  assign fifo_wr = |grant_c;
  assign owner   = owner_q;
  assign busy    = (state_q == S_OWN);

`ifdef FIFO_ARB_STATS_EN
  logic [N_REQ-1:0][STAT_W-1:0] stat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_c[i] && (stat_q[i] != {STAT_W{1'b1}})) stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=2).
// Stats scenario compiles only with FIFO_ARB_STATS_EN.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_w_data;
  logic [1:0]  owner;
  logic        busy;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] stat_cnt;
`endif

  int checks;
  int failures;

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_w_data (fifo_w_data),
    .owner       (owner),
`ifdef FIFO_ARB_STATS_EN
    .stat_cnt    (stat_cnt),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    req       = 4'b0000;
    req_data  = 32'h0;
    fifo_full = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b expected 0", fifo_wr); end
    checks++; if (busy !== 1'b0 || owner !== 2'd0) begin failures++; $display("FAIL reset_regs: busy=%b owner=%0d expected 0/0", busy, owner); end
    apply_reset();
    @(negedge clk);
    req = 4'b0010; req_data = 32'h0000_3300;
    #1;
    checks++; if (grant !== 4'b0010 || fifo_w_data !== 8'h33) begin failures++; $display("FAIL rst_first_grant: grant=%b data=%h expected 0010/33", grant, fifo_w_data); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1 || owner !== 2'd1 || grant !== 4'b0010) begin failures++; $display("FAIL rst_in_burst: busy=%b owner=%0d grant=%b expected 1/1/0010", busy, owner, grant); end
    reset = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || fifo_wr !== 1'b0) begin failures++; $display("FAIL rst_mid_drop: grant=%b wr=%b expected 0000/0", grant, fifo_wr); end
    checks++; if (busy !== 1'b0 || owner !== 2'd0 || fifo_w_data !== 8'h00) begin failures++; $display("FAIL rst_mid_regs: busy=%b owner=%0d data=%h expected 0/0/00", busy, owner, fifo_w_data); end
    @(negedge clk);
    reset = 1'b0; req = 4'b1100; req_data = 32'h4455_0000;
    #1;
    checks++; if (grant !== 4'b0100 || fifo_w_data !== 8'h55) begin failures++; $display("FAIL rst_after_release: grant=%b data=%h expected 0100/55", grant, fifo_w_data); end
  endtask

  task automatic test_single();
    logic [7:0] vals [3];
    vals[0] = 8'd5; vals[1] = 8'd8; vals[2] = 8'd2;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req = 4'b0001; req_data = {24'h0, vals[k]};
      #1;
      checks++;
      if (grant !== 4'b0001 || fifo_wr !== 1'b1 || fifo_w_data !== vals[k]) begin
        failures++;
        $display("FAIL single_%0d: grant=%b wr=%b data=%0d expected 0001/1/%0d", k, grant, fifo_wr, fifo_w_data, vals[k]);
      end
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL single_owner: got %0d expected 0", owner); end
  endtask

  task automatic test_fairness();
    int order [10];
    order = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req = 4'b1111; req_data = 32'hA3A2_A1A0;
      #1;
      checks++;
      if (grant !== (4'b0001 << order[k]) || fifo_w_data !== (8'hA0 + 8'(order[k]))) begin
        failures++;
        $display("FAIL fair_%0d: grant=%b data=%h expected idx %0d", k, grant, fifo_w_data, order[k]);
      end
    end
  endtask

  task automatic test_full_stall();
    apply_reset();
    @(negedge clk);
    req = 4'b0110; req_data = 32'h0022_1100; fifo_full = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || fifo_wr !== 1'b0) begin failures++; $display("FAIL full_idle: grant=%b wr=%b expected 0000/0", grant, fifo_wr); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_idle_lock: busy=%b expected 0", busy); end
    fifo_full = 1'b0;
    #1;
    checks++; if (grant !== 4'b0010 || fifo_w_data !== 8'h11) begin failures++; $display("FAIL full_first: grant=%b data=%h expected 0010/11", grant, fifo_w_data); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      fifo_full = 1'b1;
      #1;
      checks++;
      if (grant !== 4'b0000 || fifo_wr !== 1'b0 || busy !== 1'b1 || owner !== 2'd1) begin
        failures++;
        $display("FAIL full_stall_%0d: grant=%b wr=%b busy=%b owner=%0d expected 0000/0/1/1", k, grant, fifo_wr, busy, owner);
      end
    end
    @(negedge clk);
    fifo_full = 1'b0;
    #1;
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL full_resume: grant=%b expected 0010", grant); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0100 || fifo_w_data !== 8'h22) begin failures++; $display("FAIL full_rotate: grant=%b data=%h expected 0100/22", grant, fifo_w_data); end
  endtask

  task automatic test_early_release();
    apply_reset();
    @(negedge clk);
    req = 4'b0101; req_data = 32'h0077_0066;
    #1;
    checks++; if (grant !== 4'b0001 || fifo_w_data !== 8'h66) begin failures++; $display("FAIL early_first: grant=%b data=%h expected 0001/66", grant, fifo_w_data); end
    @(negedge clk);
    req = 4'b0100;
    #1;
    checks++; if (grant !== 4'b0000 || fifo_wr !== 1'b0 || fifo_w_data !== 8'h00) begin failures++; $display("FAIL early_bubble: grant=%b wr=%b data=%h expected 0000/0/00", grant, fifo_wr, fifo_w_data); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0100 || fifo_w_data !== 8'h77) begin failures++; $display("FAIL early_next: grant=%b data=%h expected 0100/77", grant, fifo_w_data); end
    @(negedge clk);
    #1;
    checks++; if (owner !== 2'd2 || busy !== 1'b1) begin failures++; $display("FAIL early_owner: owner=%0d busy=%b expected 2/1", owner, busy); end
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      req = 4'b1111;
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (stat_cnt[i*16 +: 16] !== 16'd4) begin
        failures++;
        $display("FAIL stats_%0d: got %0d expected 4", i, stat_cnt[i*16 +: 16]);
      end
    end
    apply_reset();
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      req = 4'b0001;
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    checks++; if (stat_cnt[15:0] !== 16'hFFFF) begin failures++; $display("FAIL stats_sat: got %0d expected 65535", stat_cnt[15:0]); end
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    req       = 4'b0000;
    req_data  = 32'h0;
    fifo_full = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_full_stall();
    test_early_release();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one fifo_unit write port among N requesters.
- Sits between producer blocks and the FIFO. Drives fifo `wr`/`w_data` directly from the granted requester; the FIFO read side is untouched.
- Grants bursts of up to MAX_BURST consecutive writes per requester, then rotates priority.
- Zero-latency valid/ready style handshake; never writes while the FIFO is full.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, FIFO data width.
- MAX_BURST, 2, maximum consecutive grants to one owner before rotation (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester write request; level, held with data until granted.
- req_data  in  N_REQ*DATA_WIDTH  flat data; slice i = req_data[i*DATA_WIDTH +: DATA_WIDTH].
- grant  out  N_REQ  one-hot; bit i high = slice i is written to the FIFO at this rising edge.
- fifo_full  in  1  full flag from fifo_unit.
- fifo_wr  out  1  write strobe to fifo_unit, equal to |grant.
- fifo_w_data  out  DATA_WIDTH  req_data slice of the granted requester; 0 when no grant.
- owner  out  clog2(N_REQ)  current/last owner index (registered).
- busy  out  1  high in state OWN.
- stat_cnt  out  N_REQ*16  present only with FIFO_ARB_STATS_EN.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, busy=0.
  - grant=0 and fifo_wr=0 are forced combinationally while reset=1.
- Handshake:
  - A requester holds req and data until it sees grant high.
  - The transfer completes at that rising edge.
  - The requester may present new data or drop req in the following cycle.
- grant, fifo_wr and fifo_w_data are combinational from state, req and fifo_full. Latency from req to FIFO write is 0 cycles.
- State IDLE:
  - winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap at N_REQ-1 -> 0.
  - If any req and !fifo_full: grant[winner]=1; owner<=winner.
    - If MAX_BURST==1: stay IDLE, rr_ptr<=winner+1 mod N_REQ.
    - Else: go to OWN with burst_cnt<=1.
  - If fifo_full: no grant, no lock, re-arbitrate next cycle.
- State OWN:
  - If req[owner] && !fifo_full: grant[owner]=1; burst_cnt++.
    - If burst_cnt+1==MAX_BURST: go to IDLE, rr_ptr<=owner+1 mod N_REQ, burst_cnt<=0.
  - If req[owner] && fifo_full: no grant; state and burst_cnt hold.
  - If !req[owner]: no grant this cycle (one bubble); go to IDLE, rr_ptr<=owner+1 mod N_REQ.
- Other requesters are never granted while in OWN. grant is always one-hot or zero.
- fifo_full is sampled combinationally, so writes stop in the same cycle full rises. The FIFO must never see wr with full=1.
- Reset asserted mid-burst: lock is abandoned; the in-flight grant is dropped and that word is not written.

Optional Feature:
- FIFO_ARB_STATS_EN:
  - Defined: per-requester 16-bit saturating grant counters on stat_cnt (slice i = grants to requester i). They hold at 65535 and clear on reset.
  - Undefined: the stat_cnt port and the counters do not exist; all other behaviour is identical.

Decomposition:
- fifo_arb_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_OWN=1'b1;
  - STAT_W=16;
  - a clog2 constant function.
- Sub-module rr_pick: combinational rotating-priority encoder (inputs req, rr_ptr; outputs winner index and valid). It is instantiated once.

Test Plan:
- Reset: N_REQ=4, MAX_BURST=2, raise reset during owner 1's burst -> grant=0, fifo_wr=0, busy=0 in the same cycle; after release, first grant goes to the lowest-indexed requester from rr_ptr=0.
- Single requester: req=0001 held 3 cycles with data 5, 8, 2 -> grant[0] on 3 consecutive cycles; FIFO receives 5, 8, 2 with no bubble.
- Fairness: req=1111 held continuously, distinct data per requester -> grant order 0,0,1,1,2,2,3,3,0,0; the rotation wraps from requester 3 to 0.
- Full stall: fifo_full=1 for 3 cycles after owner 1's first grant -> grant=0 and burst_cnt held at 1; when full drops, exactly one more grant to 1, then rotation to 2.
- Early release: req0 drops after 1 grant while req=0100 is pending -> one cycle with no grant, then grant[2]; owner=2.
- Stats (FIFO_ARB_STATS_EN): 16 cycles of req=1111 -> each stat_cnt slice = 4; force 70000 grants to requester 0 -> slice 0 saturates at 65535.
